// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-ported memory between the core (port C)
// and the debug/loader DMA (port D). Define MEM_ARB_TIMEOUT_EN to enable the BUSY timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                c_read,
    input  logic                c_write,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wmask,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_resp,
    output logic                c_err,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                d_err,
    output logic                m_read,
    output logic                m_write,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_resp,
    output logic                grant,
    output logic [1:0]          dbg_state
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    state_t state, state_n;

    // Handshake: x_read/x_write are one-cycle strobes with no back-pressure; a strobe that
    // finds its slot occupied is dropped. m_read/m_write stay high until the one-cycle m_resp.
    logic                c_slot_v, c_slot_w, d_slot_v, d_slot_w;
    logic [ADDR_W-1:0]   c_slot_addr, d_slot_addr;
    logic [DATA_W-1:0]   c_slot_wdata, d_slot_wdata;
    logic [MASK_W-1:0]   c_slot_wmask, d_slot_wmask;
    logic                c_set, c_clr, d_set, d_clr;
    logic                last_grant;
    logic                load, sel_d, done, timed_out, timeout_hit;
    logic [DATA_W-1:0]   resp_data;

    assign dbg_state = state;

    assign c_clr = (state == RESP) && !grant;
    assign d_clr = (state == RESP) && grant;
    assign c_set = (c_read || c_write) && (!c_slot_v || c_clr);
    assign d_set = (d_read || d_write) && (!d_slot_v || d_clr);

    // A set in the response cycle wins over the clear so a re-issued strobe is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_slot_v     <= 1'b0;
            c_slot_w     <= 1'b0;
            c_slot_addr  <= '0;
            c_slot_wdata <= '0;
            c_slot_wmask <= '0;
            d_slot_v     <= 1'b0;
            d_slot_w     <= 1'b0;
            d_slot_addr  <= '0;
            d_slot_wdata <= '0;
            d_slot_wmask <= '0;
        end else begin
            if (c_set) begin
                c_slot_v     <= 1'b1;
                c_slot_w     <= c_write;
                c_slot_addr  <= c_addr;
                c_slot_wdata <= c_wdata;
                c_slot_wmask <= c_wmask;
            end else if (c_clr) begin
                c_slot_v <= 1'b0;
            end
            if (d_set) begin
                d_slot_v     <= 1'b1;
                d_slot_w     <= d_write;
                d_slot_addr  <= d_addr;
                d_slot_wdata <= d_wdata;
                d_slot_wmask <= d_wmask;
            end else if (d_clr) begin
                d_slot_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        sel_d     = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (c_slot_v || d_slot_v) begin
                    load    = 1'b1;
                    sel_d   = d_slot_v && (!c_slot_v || !last_grant);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (m_resp) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                    state_n   = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign resp_data = timed_out ? DATA_W'(32'hDEAD_BEEF) : m_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wmask    <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            c_resp     <= 1'b0;
            d_resp     <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            c_resp <= 1'b0;
            d_resp <= 1'b0;
            if (load) begin
                grant      <= sel_d;
                last_grant <= sel_d;
                m_read     <= sel_d ? !d_slot_w : !c_slot_w;
                m_write    <= sel_d ? d_slot_w : c_slot_w;
                m_addr     <= sel_d ? d_slot_addr : c_slot_addr;
                m_wdata    <= sel_d ? d_slot_wdata : c_slot_wdata;
                m_wmask    <= sel_d ? d_slot_wmask : c_slot_wmask;
            end
            if (done || timed_out) begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
                if (grant) begin
                    d_resp  <= 1'b1;
                    d_rdata <= resp_data;
                end else begin
                    c_resp  <= 1'b1;
                    c_rdata <= resp_data;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;

    // Counts BUSY cycles without a response; a late m_resp after RESP is simply not looked at.
    always_ff @(posedge clk) begin
        if (!rst_n || load)                to_cnt <= '0;
        else if (state == BUSY && !m_resp) to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state == BUSY) && !m_resp && (to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            c_err <= timed_out && !grant;
            d_err <= timed_out && grant;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign c_err       = 1'b0;
    assign d_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic checked against a
// transaction-level model of the two pending slots, round-robin choice and a memory array.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk, rst_n;
    logic                c_read, c_write, d_read, d_write;
    logic [ADDR_W-1:0]   c_addr, d_addr, m_addr;
    logic [DATA_W-1:0]   c_wdata, d_wdata, m_wdata, c_rdata, d_rdata, m_rdata;
    logic [DATA_W/8-1:0] c_wmask, d_wmask, m_wmask;
    logic                c_resp, c_err, d_resp, d_err;
    logic                m_read, m_write, m_resp, grant;
    logic [1:0]          dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_wmask(c_wmask), .c_rdata(c_rdata), .c_resp(c_resp), .c_err(c_err),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp), .d_err(d_err),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata), .m_resp(m_resp), .grant(grant),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge clk);
        c_read  = 1'b0;
        c_write = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        m_resp  = 1'b0;
    endtask

    task automatic clear_inputs();
        c_read = 0; c_write = 0; c_addr = '0; c_wdata = '0; c_wmask = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        m_resp = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the memory request, checks it, holds it for `waits` cycles,
    // responds and checks the response pulse. Optional C read strobes mid-BUSY / in RESP.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_port,
                         input logic exp_w, input int waits, input logic [31:0] rdata,
                         input int exp_lat, input int c_mid_at, input logic [31:0] c_mid_addr,
                         input logic c_resp_strobe, input logic [31:0] c_resp_addr);
        int lat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(m_read || m_write) && lat < 20);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_grant"}, grant, exp_port);
        chk({tag, "_m_read"}, m_read, !exp_w);
        chk({tag, "_m_write"}, m_write, exp_w);
        chk({tag, "_m_addr"}, m_addr, exp_addr);
        for (int w = 0; w < waits; w++) begin
            if (w == c_mid_at) begin
                c_read = 1'b1;
                c_addr = c_mid_addr;
            end
            tick();
            chk({tag, "_held_req"}, m_read || m_write, 1'b1);
            chk({tag, "_held_addr"}, m_addr, exp_addr);
            chk({tag, "_held_grant"}, grant, exp_port);
        end
        m_resp  = 1'b1;
        m_rdata = rdata;
        tick();
        chk({tag, "_req_drop"}, m_read || m_write, 1'b0);
        chk({tag, "_c_resp"}, c_resp, !exp_port);
        chk({tag, "_d_resp"}, d_resp, exp_port);
        chk({tag, "_rdata"}, exp_port ? d_rdata : c_rdata, rdata);
        chk({tag, "_err"}, {c_err, d_err}, 2'b00);
        if (c_resp_strobe) begin
            c_read = 1'b1;
            c_addr = c_resp_addr;
        end
        tick();
        chk({tag, "_resp_end"}, {c_resp, d_resp}, 2'b00);
    endtask

    task automatic rand_strobe(input logic port, output req_t r);
        int kind;
        kind    = $urandom_range(0, 2);
        r.w     = (kind != 0);
        r.addr  = 32'($urandom_range(0, 15)) << 2;
        r.wdata = $urandom;
        r.wmask = 4'($urandom_range(0, 15));
        if (!port) begin
            c_read = (kind != 1); c_write = (kind != 0);
            c_addr = r.addr; c_wdata = r.wdata; c_wmask = r.wmask;
        end else begin
            d_read = (kind != 1); d_write = (kind != 0);
            d_addr = r.addr; d_wdata = r.wdata; d_wmask = r.wmask;
        end
    endtask

    // scoreboard / reference model state
    logic [31:0] mem [16];
    logic [31:0] exp_q[$];
    req_t        req_c, req_d, held, tmp;
    logic        vc, vd, vc_prev, vd_prev, prev_idle, last_g;
    logic        mem_active, resp_due, due_port, held_port, mreq, rise, exp_c, exp_d, nc, nd;
    logic [31:0] rd;
    int          wait_left;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        chk("rst_m_req", {m_read, m_write}, 2'b00);
        chk("rst_m_fields", {m_addr, m_wdata}, 64'd0);
        chk("rst_m_wmask", m_wmask, 4'd0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_resp", {c_resp, d_resp, c_err, d_err}, 4'd0);
        chk("rst_rdata", {c_rdata, d_rdata}, 64'd0);
        chk("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        // C read at 0x100, zero wait
        c_read = 1'b1; c_addr = 32'h100;
        serve("t1", 32'h100, 1'b0, 1'b0, 0, 32'h1234_5678, 2, -1, 0, 1'b0, 0);
        chk("t1_rdata_hold", c_rdata, 32'h1234_5678);

        // simultaneous C/D writes, twice: C first both times
        do_reset();
        c_write = 1; c_addr = 32'h200; c_wdata = 32'hAAAA_0001; c_wmask = 4'hF;
        d_write = 1; d_addr = 32'h300; d_wdata = 32'hBBBB_0002; d_wmask = 4'h3;
        serve("t2a", 32'h200, 1'b0, 1'b1, 0, 32'h0, 2, -1, 0, 1'b0, 0);
        serve("t2b", 32'h300, 1'b1, 1'b1, 0, 32'h0, 1, -1, 0, 1'b0, 0);
        c_write = 1; c_addr = 32'h204;
        d_write = 1; d_addr = 32'h304;
        serve("t2c", 32'h204, 1'b0, 1'b1, 0, 32'h0, 2, -1, 0, 1'b0, 0);
        serve("t2d", 32'h304, 1'b1, 1'b1, 0, 32'h0, 1, -1, 0, 1'b0, 0);

        // D read with 5 wait states, C strobes mid-BUSY
        d_read = 1; d_addr = 32'h400;
        serve("t3a", 32'h400, 1'b1, 1'b0, 5, 32'hD00D_0400, 2, 2, 32'h500, 1'b0, 0);
        serve("t3b", 32'h500, 1'b0, 1'b0, 0, 32'hC00C_0500, 1, -1, 0, 1'b0, 0);

        // C re-strobe while pending is dropped; strobe in the c_resp cycle is kept
        c_read = 1; c_addr = 32'h700;
        serve("t4a", 32'h700, 1'b0, 1'b0, 2, 32'h7777_0700, 2, 1, 32'h7F0, 1'b1, 32'h704);
        serve("t4b", 32'h704, 1'b0, 1'b0, 0, 32'h7777_0704, 1, -1, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_idle", {m_read, m_write}, 2'b00);
        end

        // reset during BUSY
        c_read = 1; c_addr = 32'h800;
        tick();
        tick();
        chk("t5_busy", m_read, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("t5_req_drop", {m_read, m_write}, 2'b00);
        chk("t5_no_resp", {c_resp, d_resp}, 2'b00);
        chk("t5_grant", grant, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_quiet", {m_read, m_write, c_resp, d_resp}, 4'd0);
        end
        c_read = 1; c_addr = 32'h804;
        serve("t5_after", 32'h804, 1'b0, 1'b0, 0, 32'h8888_0804, 2, -1, 0, 1'b0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers: 8 BUSY cycles then an error response
        c_read = 1; c_addr = 32'h600;
        tick();
        tick();
        chk("to_req", m_read, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_held", m_read, 1'b1);
        end
        tick();
        chk("to_drop", m_read, 1'b0);
        chk("to_resp", {c_resp, c_err, d_resp}, 3'b110);
        chk("to_rdata", c_rdata, 32'hDEAD_BEEF);
        tick();
        chk("to_resp_end", {c_resp, c_err}, 2'b00);
`endif

        // randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        vc = 0; vd = 0; vc_prev = 0; vd_prev = 0; prev_idle = 1; last_g = 1;
        mem_active = 0; resp_due = 0; due_port = 0; held_port = 0; wait_left = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            mreq  = m_read || m_write;
            exp_c = resp_due && !due_port;
            exp_d = resp_due && due_port;
            chk("rnd_c_resp", c_resp, exp_c);
            chk("rnd_d_resp", d_resp, exp_d);
            chk("rnd_err", {c_err, d_err}, 2'b00);
            if (resp_due) begin
                chk(due_port ? "rnd_d_rdata" : "rnd_c_rdata", due_port ? d_rdata : c_rdata,
                    exp_q.pop_front());
            end
            resp_due = 0;

            rise = mreq && !mem_active;
            chk("rnd_req_start", rise, prev_idle && (vc_prev || vd_prev));
            if (mem_active) chk("rnd_req_held", mreq, 1'b1);
            if (rise) begin
                held_port = (vc_prev && vd_prev) ? !last_g : vd_prev;
                last_g    = held_port;
                held      = held_port ? req_d : req_c;
                chk("rnd_grant", grant, held_port);
                chk("rnd_kind", {m_read, m_write}, {!held.w, held.w});
                chk("rnd_addr", m_addr, held.addr);
                chk("rnd_wdata", m_wdata, held.wdata);
                chk("rnd_wmask", m_wmask, held.wmask);
                mem_active = 1;
                wait_left  = $urandom_range(0, 3);
            end else if (mem_active) begin
                chk("rnd_stable_grant", grant, held_port);
                chk("rnd_stable_addr", m_addr, held.addr);
                chk("rnd_stable_kind", m_write, held.w);
            end

            // memory responder
            if (mem_active && mreq) begin
                if (wait_left == 0) begin
                    if (held.w) begin
                        rd = $urandom;
                        for (int b = 0; b < 4; b++)
                            if (held.wmask[b]) mem[held.addr[5:2]][b*8 +: 8] = held.wdata[b*8 +: 8];
                    end else begin
                        rd = mem[held.addr[5:2]];
                    end
                    m_resp  = 1'b1;
                    m_rdata = rd;
                    exp_q.push_back(rd);
                    resp_due   = 1;
                    due_port   = held_port;
                    mem_active = 0;
                end else begin
                    wait_left--;
                end
            end

            // strobes: occasionally hit an occupied slot, which must be ignored
            nc = exp_c ? 1'b0 : vc;
            nd = exp_d ? 1'b0 : vd;
            if ($urandom_range(0, 9) < ((vc && !exp_c) ? 1 : 3)) begin
                rand_strobe(1'b0, tmp);
                if (!vc || exp_c) begin
                    nc    = 1;
                    req_c = tmp;
                end
            end
            if ($urandom_range(0, 9) < ((vd && !exp_d) ? 1 : 3)) begin
                rand_strobe(1'b1, tmp);
                if (!vd || exp_d) begin
                    nd    = 1;
                    req_d = tmp;
                end
            end
            prev_idle = !mreq && !exp_c && !exp_d;
            vc_prev   = vc;
            vd_prev   = vd;
            vc        = nc;
            vd        = nd;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-ported memory between two requesters: port C (the multicycle core control/datapath) and port D (debug/loader DMA).
- Each requester issues one-cycle read/write strobes. The arbiter latches each strobe into a per-port pending slot and serves the slots one at a time, with round-robin priority.
- It drives a level-held request to memory, waits for `m_resp`, and returns a one-cycle response pulse with read data to the owning port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (`wmask` width = DATA_W/8)
- TIMEOUT, 255, BUSY-cycle limit; used only when `MEM_ARB_TIMEOUT_EN` is defined

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- c_read, c_write  in  1  port C one-cycle strobes
- c_addr  in  ADDR_W  port C address, sampled on strobe
- c_wdata  in  DATA_W  port C write data, sampled on strobe
- c_wmask  in  DATA_W/8  port C byte enables, sampled on strobe
- c_rdata  out  DATA_W  port C read data, valid while `c_resp`
- c_resp  out  1  port C one-cycle completion pulse
- c_err  out  1  port C timeout pulse, coincident with `c_resp`
- d_read, d_write, d_addr, d_wdata, d_wmask, d_rdata, d_resp, d_err  same as port C, for port D
- m_read, m_write  out  1  memory request, level-held until `m_resp`
- m_addr, m_wdata, m_wmask  out  as above  memory request fields, registered
- m_rdata  in  DATA_W  memory read data, valid with `m_resp`
- m_resp  in  1  memory completion, one cycle
- grant  out  1  owner of the current transaction (0 = C, 1 = D), registered

## Operation
Pending slots (one per port):
- Fields: valid, is_write, addr, wdata, wmask.
- A strobe sets the slot at the next edge.
- If read and write are strobed together, the request is a write.
- A strobe while the slot is already valid is ignored; the slot is unchanged.
- A strobe in the same cycle the slot's own `x_resp` fires is accepted: set wins over clear.

FSM states:
- IDLE:
  - If no slot is valid, stay in IDLE.
  - If only one slot is valid, select it.
  - If both are valid, select the port that is not `last_grant`.
  - On selection, load the `m_*` registers and `grant`, set `last_grant`, go to BUSY.
- BUSY:
  - Hold `m_read`/`m_write` and the `m_*` fields stable.
  - On `m_resp`, capture `m_rdata` (writes capture it too; the value is don't-care), clear `m_read`/`m_write`, go to RESP.
- RESP:
  - Pulse `x_resp` for the granted port and drive the captured data on `x_rdata`.
  - Clear that port's slot and go to IDLE.

Other rules:
- `last_grant` resets to 1, so port C wins the first tie.
- `x_rdata` holds its last value outside `x_resp`. The other port's `x_resp` stays 0.
- An arriving strobe never preempts a transaction already in BUSY.
- Reset values: all slots invalid, state IDLE, `last_grant` = 1, `grant` = 0. All of `m_read`, `m_write`, `m_addr`, `m_wdata`, `m_wmask`, `c_*`/`d_*` outputs are 0.
- Reset mid-BUSY: `m_read`/`m_write` drop at the same edge. The in-flight transaction is abandoned and no response is returned. The memory must tolerate the withdrawn request.

## Timing
Zero-wait memory, `m_resp` in the first BUSY cycle:
- Cycle 0: strobe.
- Cycle 1: slot valid, state IDLE.
- Cycle 2: BUSY, `m_read` = 1, `m_resp` = 1.
- Cycle 3: RESP, `x_resp` = 1.
- Cycle 4: IDLE. The next grant puts the memory request up in cycle 5.

Throughput and waits:
- Back-to-back alternating service costs 3 cycles per transaction plus memory wait states.
- Each memory wait state adds one BUSY cycle.
- Worst-case wait for a port while the other is also pending: one full transaction.

## Configuration
`MEM_ARB_TIMEOUT_EN` defined:
- A counter clears on entry to BUSY and increments each BUSY cycle without `m_resp`.
- When the counter reaches TIMEOUT, the arbiter clears `m_read`/`m_write` and goes to RESP.
- In that RESP cycle, `x_rdata` = 32'hDEAD_BEEF and `x_err` = 1 together with `x_resp`.
- An `m_resp` arriving after the timeout is ignored.

`MEM_ARB_TIMEOUT_EN` undefined:
- No counter is built; BUSY waits indefinitely.
- `c_err`/`d_err` are tied 0.

## Test plan
- C read strobe, addr 0x100, memory returns 0x1234_5678 with zero wait -> `m_read` high in cycle 2 only; `c_resp` = 1 with `c_rdata` = 0x1234_5678 in cycle 3; `d_resp` = 0 throughout.
- C and D write strobes in the same cycle after reset -> C served first, then D. The `m_addr` sequence is C's address then D's; `grant` goes 0 then 1. A second simultaneous pair is served C first again, because `last_grant` is then 1.
- D read with 5 memory wait states while C strobes mid-BUSY -> `m_read`/`m_addr` stay stable for 6 BUSY cycles; `d_resp` fires first, then C is granted in the following IDLE.
- C re-strobes with a different address while its slot is pending -> the second strobe is ignored; only the original address appears on `m_addr`. A strobe in the `c_resp` cycle is accepted and served next.
- `rst_n` low during BUSY -> `m_read` = 0 at the next edge; no `c_resp`/`d_resp`; all slots empty; a new C strobe after reset completes normally.
- With `MEM_ARB_TIMEOUT_EN` and TIMEOUT = 8, memory never responds -> `m_read` drops after 8 BUSY cycles; next cycle `c_resp` = 1, `c_err` = 1, `c_rdata` = 0xDEAD_BEEF.
